// File: rtl/mmio_console_tx.sv
// mmio_console_tx
//
// MMIO console and finish device that snoops the core's DCCM store bus.
//   - A store to CONSOLE_ADDR queues wdata[7:0] in a TX FIFO. The FIFO is
//     drained as UART 8N1 (LSB first) on tx.
//   - A store to FINISH_ADDR latches a sticky halt flag and an exit code.
//   - STATUS_ADDR can be read (FIFO/console state) and written (bit 2 clears
//     the sticky overflow flag).
//
// Optional build macro: MMIO_CONSOLE_DRAIN_EN
//   When defined, halt is held off until every queued character has been
//   sent: FIFO empty and serializer idle. exit_code still latches on the
//   finish store.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   dccm_wen/waddr/wdata store snoop: one-cycle strobe, address, data
//   dccm_ren/raddr       load snoop: one-cycle strobe, address
//   mmio_rdata/rvalid    status read response, registered (cycle after ren)
//   tx                   UART serial out, idle high
//   halt                 sticky finish flag
//   exit_code            wdata of the first finish store
//
// Status word: [0] empty [1] full [2] overflow [3] busy [4] halt
//              [15:8] FIFO count. All other bits read as 0.
module mmio_console_tx #(
    parameter int unsigned         XLEN         = 32,
    parameter logic [XLEN-1:0]     CONSOLE_ADDR = 32'h00200000,
    parameter logic [XLEN-1:0]     STATUS_ADDR  = 32'h00200004,
    parameter logic [XLEN-1:0]     FINISH_ADDR  = 32'h10000000,
    parameter int unsigned         FIFO_DEPTH   = 16,
    parameter int unsigned         CLKS_PER_BIT = 868
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dccm_wen,
    input  logic [XLEN-1:0] dccm_waddr,
    input  logic [XLEN-1:0] dccm_wdata,
    input  logic            dccm_ren,
    input  logic [XLEN-1:0] dccm_raddr,
    output logic [XLEN-1:0] mmio_rdata,
    output logic            mmio_rvalid,
    output logic            tx,
    output logic            halt,
    output logic [XLEN-1:0] exit_code
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              tx_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              halt_q;
    logic [XLEN-1:0]   exit_q;
    logic              rvalid_q;
    logic [XLEN-1:0]   rdata_q;

    logic              push_req, push_ok, pop, fin_store, status_hit;
    logic              empty, full, busy;
    logic [XLEN-1:0]   status;

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = (state_q == S_IDLE) && !empty;
        push_req   = dccm_wen && (dccm_waddr == CONSOLE_ADDR);
        // A full FIFO still takes the byte when the head leaves in the same cycle.
        push_ok    = push_req && (!full || pop);
        fin_store  = dccm_wen && (dccm_waddr == FINISH_ADDR);
        status_hit = dccm_ren && (dccm_raddr == STATUS_ADDR);
        busy       = (state_q != S_IDLE) || !empty;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Overflow set has priority over a same-cycle clear.
        ovf_d = ovf_q;
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end else if (dccm_wen && (dccm_waddr == STATUS_ADDR) && dccm_wdata[2]) begin
            ovf_d = 1'b0;
        end

        status        = '0;
        status[0]     = empty;
        status[1]     = full;
        status[2]     = ovf_q;
        status[3]     = busy;
        status[4]     = halt_q;
        status[15:8]  = 8'(count_q);
    end

    // FIFO storage holds data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dccm_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // UART serializer. baud_q counts down from CLKS_PER_BIT-1 in every bit
    // period, so each bit lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= BAUD_LAST;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_q == '0) begin
                        baud_q  <= BAUD_LAST;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_q == '0) begin
                        baud_q <= BAUD_LAST;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            // Bit 1 of the current shift value is the next bit on the wire.
                            tx_q    <= shift_q[1];
                            shift_q <= shift_q >> 1;
                            bit_q   <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status read response, registered one cycle after the load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= status_hit;
            rdata_q  <= status_hit ? status : '0;
        end
    end

`ifdef MMIO_CONSOLE_DRAIN_EN
    logic pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            halt_q <= 1'b0;
            exit_q <= '0;
        end else begin
            if (fin_store && !pend_q) begin
                pend_q <= 1'b1;
                exit_q <= dccm_wdata;
            end
            if (pend_q && empty && (state_q == S_IDLE)) begin
                halt_q <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q <= 1'b0;
            exit_q <= '0;
        end else if (fin_store && !halt_q) begin
            halt_q <= 1'b1;
            exit_q <= dccm_wdata;
        end
    end
`endif

    assign tx          = tx_q;
    assign halt        = halt_q;
    assign exit_code   = exit_q;
    assign mmio_rvalid = rvalid_q;
    assign mmio_rdata  = rdata_q;
endmodule

// File: tb/tb_mmio_console_tx.sv
module tb_mmio_console_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam logic [31:0] CON_A = 32'h00200000;
    localparam logic [31:0] STA_A = 32'h00200004;
    localparam logic [31:0] FIN_A = 32'h10000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dccm_wen = 1'b0;
    logic [31:0] dccm_waddr = '0;
    logic [31:0] dccm_wdata = '0;
    logic        dccm_ren = 1'b0;
    logic [31:0] dccm_raddr = '0;
    logic [31:0] mmio_rdata;
    logic        mmio_rvalid;
    logic        tx;
    logic        halt;
    logic [31:0] exit_code;

    int checks = 0;
    int errors = 0;

    mmio_console_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .dccm_wen(dccm_wen), .dccm_waddr(dccm_waddr), .dccm_wdata(dccm_wdata),
        .dccm_ren(dccm_ren), .dccm_raddr(dccm_raddr),
        .mmio_rdata(mmio_rdata), .mmio_rvalid(mmio_rvalid),
        .tx(tx), .halt(halt), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: a byte queue plus "frame in progress since cycle X".
    // The wire level is derived from the position inside the 10-bit frame.
    byte unsigned mq[$];
    bit          m_active, m_ovf, m_halt, m_pend, model_ok;
    int          m_pos;
    logic [7:0]  m_byte;
    logic [31:0] m_exit, m_rdata;
    logic        m_tx, m_rvalid;

    always @(posedge clk) begin : model
        bit          pop, push, acc;
        logic [31:0] st;
        int          slot;
        if (rst) begin
            mq.delete();
            m_active = 0; m_pos = 0; m_ovf = 0; m_halt = 0; m_pend = 0;
            m_exit = '0; m_tx = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
            model_ok = 1;
        end else begin
            st = {16'h0, 8'(mq.size()), 3'b000, m_halt, (m_active || mq.size() > 0),
                  m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
            m_rvalid = dccm_ren && (dccm_raddr == STA_A);
            m_rdata  = m_rvalid ? st : 32'h0;
`ifdef MMIO_CONSOLE_DRAIN_EN
            if (m_pend && mq.size() == 0 && !m_active) m_halt = 1;
`endif
            pop  = !m_active && mq.size() > 0;
            push = dccm_wen && (dccm_waddr == CON_A);
            acc  = push && (mq.size() < DEPTH || pop);
            if (pop) begin
                m_byte = mq.pop_front();
                m_active = 1;
                m_pos = 0;
            end else if (m_active) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_active = 0;
            end
            if (acc) mq.push_back(dccm_wdata[7:0]);
            if (push && !acc) m_ovf = 1;
            else if (dccm_wen && dccm_waddr == STA_A && dccm_wdata[2]) m_ovf = 0;
            if (dccm_wen && dccm_waddr == FIN_A) begin
`ifdef MMIO_CONSOLE_DRAIN_EN
                if (!m_pend) begin m_pend = 1; m_exit = dccm_wdata; end
`else
                if (!m_halt) begin m_halt = 1; m_exit = dccm_wdata; end
`endif
            end
            slot = m_pos / CPB;
            if (!m_active)      m_tx = 1'b1;
            else if (slot == 0) m_tx = 1'b0;
            else if (slot == 9) m_tx = 1'b1;
            else                m_tx = m_byte[slot-1];
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("tx", {31'b0, tx}, {31'b0, m_tx});
            check("halt", {31'b0, halt}, {31'b0, m_halt});
            check("exit_code", exit_code, m_exit);
            check("rvalid", {31'b0, mmio_rvalid}, {31'b0, m_rvalid});
            check("rdata", mmio_rdata, m_rdata);
        end
    end

    // UART receiver on the DUT's tx line, sampling mid-bit.
    byte unsigned rxq[$];
    int          rx_t = -1;
    logic [7:0]  rx_b;
    always @(negedge clk) begin
        if (rst) begin
            rx_t = -1;
        end else if (rx_t < 0) begin
            if (tx === 1'b0) rx_t = 0;
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8)
                rx_b[rx_t / CPB - 1] = tx;
            if (rx_t == 9 * CPB + CPB / 2) begin
                rxq.push_back(rx_b);
                rx_t = -1;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        dccm_wen = 1'b1; dccm_waddr = a; dccm_wdata = d;
        tick();
        dccm_wen = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        dccm_ren = 1'b1; dccm_raddr = a;
        tick();
        dccm_ren = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(3);
        rst = 1'b0;
        check("rst_tx", {31'b0, tx}, 32'h1);
        check("rst_halt", {31'b0, halt}, 32'h0);
        check("rst_rvalid", {31'b0, mmio_rvalid}, 32'h0);
        load(STA_A);
        check("rst_status", mmio_rdata, 32'h00000001);
        check("rst_status_vld", {31'b0, mmio_rvalid}, 32'h1);

        // Single character 0x41: start bit begins two cycles after the store
        store(CON_A, 32'h41);
        check("lat_n1_tx", {31'b0, tx}, 32'h1);
        tick();
        check("lat_n2_tx", {31'b0, tx}, 32'h0);
        tick(3);
        check("start_last_tx", {31'b0, tx}, 32'h0);
        tick();
        check("bit0_tx", {31'b0, tx}, 32'h1);
        tick(45);
        check("rx_count_41", rxq.size(), 32'd1);
        if (rxq.size() >= 1) check("rx_41", {24'b0, rxq[0]}, 32'h41);

        // Six back-to-back stores into a depth-4 FIFO
        rxq.delete();
        for (int i = 0; i < 6; i++) store(CON_A, 32'h30 + i);
        load(STA_A);
        check("ovf_status", mmio_rdata, 32'h0000040E);
        tick(5 * 41 + 10);
        check("rx_count_30", rxq.size(), 32'd5);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            check("rx_seq", {24'b0, rxq[i]}, 32'h30 + i);

        // Overflow clear via status write
        store(STA_A, 32'h4);
        load(STA_A);
        check("ovf_clr", mmio_rdata, 32'h00000001);

        // Finish: first store wins
        store(FIN_A, 32'h2A);
        check("exit_first", exit_code, 32'h2A);
`ifdef MMIO_CONSOLE_DRAIN_EN
        check("halt_n1", {31'b0, halt}, 32'h0);
        tick();
`endif
        check("halt_set", {31'b0, halt}, 32'h1);
        store(FIN_A, 32'h7);
        check("exit_kept", exit_code, 32'h2A);
        load(STA_A);
        check("halt_status", mmio_rdata, 32'h00000011);
        rxq.delete();
        store(CON_A, 32'h55);
        tick(45);
        check("rx_after_halt_n", rxq.size(), 32'd1);
        if (rxq.size() >= 1) check("rx_after_halt", {24'b0, rxq[0]}, 32'h55);

        // Reset in the middle of the data bits truncates the frame
        rxq.delete();
        store(CON_A, 32'h5A);
        tick(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx", {31'b0, tx}, 32'h1);
        check("mid_rst_halt", {31'b0, halt}, 32'h0);
        load(STA_A);
        check("mid_rst_status", mmio_rdata, 32'h00000001);
        tick(50);
        check("no_residual", rxq.size(), 32'd0);

        // Unmapped load and a status read with three bytes queued
        load(32'h00200008);
        check("bad_rvalid", {31'b0, mmio_rvalid}, 32'h0);
        check("bad_rdata", mmio_rdata, 32'h0);
        for (int i = 0; i < 4; i++) store(CON_A, 32'h61 + i);
        load(STA_A);
        check("q3_status", mmio_rdata, 32'h00000308);
        tick(4 * 41 + 10);

`ifdef MMIO_CONSOLE_DRAIN_EN
        // Halt waits for both queued characters to finish
        begin
            int w;
            rst = 1'b1; tick(); rst = 1'b0;
            rxq.delete();
            store(CON_A, 32'h71);
            store(CON_A, 32'h72);
            store(FIN_A, 32'h3);
            check("drain_early", {31'b0, halt}, 32'h0);
            tick(60);
            check("drain_mid", {31'b0, halt}, 32'h0);
            w = 0;
            while (halt !== 1'b1 && w < 200) begin tick(); w++; end
            check("drain_halt", {31'b0, halt}, 32'h1);
            check("drain_rx", rxq.size(), 32'd2);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
